// File: rtl/snn_pkg.sv
// Shared spiking-network widths and the weight saturating-update helper.
package snn_pkg;

   localparam int unsigned W_WIDTH     = 8;
   localparam int unsigned TRACE_WIDTH = 4;

   // weight + ltp - ltd in W_WIDTH+2 signed arithmetic, clamped to [0, 2^W_WIDTH-1]
   function automatic logic [W_WIDTH-1:0] sat_add(input logic [W_WIDTH-1:0] weight,
                                                  input logic [W_WIDTH-1:0] ltp,
                                                  input logic [W_WIDTH-1:0] ltd);
      logic signed [W_WIDTH+1:0] sum;
      sum = $signed({2'b00, weight}) + $signed({2'b00, ltp}) - $signed({2'b00, ltd});
      if (sum[W_WIDTH+1])
         return '0;
      else if (sum[W_WIDTH])
         return '1;
      else
         return sum[W_WIDTH-1:0];
   endfunction

endpackage

// File: rtl/spike_trace.sv
// Decaying spike trace: reloads to full scale on a spike, otherwise counts down to zero.
module spike_trace #(
   parameter int unsigned TRACE_WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   spike,
   output logic [TRACE_WIDTH-1:0] trace
);

   always_ff @(posedge clk) begin
      if (rst)
         trace <= '0;
      else if (spike)
         trace <= '1;
      else if (trace != '0)
         trace <= trace - TRACE_WIDTH'(1);
   end

endmodule

// File: rtl/stdp_synapse.sv
// Plastic synapse: weighted current pulse per presynaptic spike, pair-based STDP weight update.
module stdp_synapse
   import snn_pkg::*;
#(
   parameter int unsigned W_INIT  = 64,
   parameter int unsigned A_PLUS  = 32,
   parameter int unsigned A_MINUS = 24
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   pre_spike,
   input  logic                   post_spike,
   input  logic                   learn_en,
   input  logic                   weight_load,
   input  logic [W_WIDTH-1:0]     weight_in,
   output logic [W_WIDTH-1:0]     current,
   output logic [W_WIDTH-1:0]     weight,
   output logic [TRACE_WIDTH-1:0] pre_trace,
   output logic [TRACE_WIDTH-1:0] post_trace,
   output logic                   ltp_event,
   output logic                   ltd_event
);

   localparam int unsigned P_WIDTH = TRACE_WIDTH + W_WIDTH;

   logic [P_WIDTH-1:0] prod_plus;
   logic [P_WIDTH-1:0] prod_minus;
   logic [W_WIDTH-1:0] ltp_term;
   logic [W_WIDTH-1:0] ltd_term;
   logic [W_WIDTH-1:0] weight_next;
   logic               ltp_hit;
   logic               ltd_hit;

   spike_trace #(.TRACE_WIDTH(TRACE_WIDTH)) u_pre_trace (
      .clk   (clk),
      .rst   (rst),
      .spike (pre_spike),
      .trace (pre_trace)
   );

   spike_trace #(.TRACE_WIDTH(TRACE_WIDTH)) u_post_trace (
      .clk   (clk),
      .rst   (rst),
      .spike (post_spike),
      .trace (post_trace)
   );

   // Both terms look at the traces as held before this edge, so pairing is causal.
   always_comb begin
      ltp_hit     = post_spike & learn_en & (pre_trace != '0);
      ltd_hit     = pre_spike & learn_en & (post_trace != '0);
      prod_plus   = P_WIDTH'(pre_trace) * P_WIDTH'(A_PLUS);
      prod_minus  = P_WIDTH'(post_trace) * P_WIDTH'(A_MINUS);
      ltp_term    = ltp_hit ? prod_plus[P_WIDTH-1:TRACE_WIDTH] : '0;
      ltd_term    = ltd_hit ? prod_minus[P_WIDTH-1:TRACE_WIDTH] : '0;
      weight_next = sat_add(weight, ltp_term, ltd_term);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         weight    <= W_WIDTH'(W_INIT);
         current   <= '0;
         ltp_event <= 1'b0;
         ltd_event <= 1'b0;
      end else begin
         current   <= pre_spike ? weight : '0;
         ltp_event <= ltp_hit;
         ltd_event <= ltd_hit;
         weight    <= weight_load ? weight_in : weight_next;
      end
   end

endmodule

// File: tb/tb_stdp_synapse.sv
// Scoreboard bench for stdp_synapse: a behavioural model queues expected outputs per edge.
module tb_stdp_synapse;

   logic       clk = 1'b0;
   logic       rst;
   logic       pre_spike;
   logic       post_spike;
   logic       learn_en;
   logic       weight_load;
   logic [7:0] weight_in;
   logic [7:0] current;
   logic [7:0] weight;
   logic [3:0] pre_trace;
   logic [3:0] post_trace;
   logic       ltp_event;
   logic       ltd_event;

   typedef struct {
      int cur;
      int w;
      int pt;
      int qt;
      int ltp;
      int ltd;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   // reference state
   int m_w   = 64;
   int m_pt  = 0;
   int m_qt  = 0;

   stdp_synapse dut (
      .clk         (clk),
      .rst         (rst),
      .pre_spike   (pre_spike),
      .post_spike  (post_spike),
      .learn_en    (learn_en),
      .weight_load (weight_load),
      .weight_in   (weight_in),
      .current     (current),
      .weight      (weight),
      .pre_trace   (pre_trace),
      .post_trace  (post_trace),
      .ltp_event   (ltp_event),
      .ltd_event   (ltd_event)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int expv);
      checks++;
      if (obs != expv) begin
         failures++;
         $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, expv, $time);
      end
   endtask

   // Drive one edge worth of stimulus, push the model's prediction, then compare after the edge.
   task automatic step(input logic r, input logic pre, input logic post,
                       input logic le, input logic ld, input int lv);
      exp_t e;
      int   dp, dm, s;
      bit   hp, hm;
      if (r) begin
         e = '{cur: 0, w: 64, pt: 0, qt: 0, ltp: 0, ltd: 0};
      end else begin
         hp = post && le && (m_pt != 0);
         hm = pre && le && (m_qt != 0);
         dp = hp ? (m_pt * 32) / 16 : 0;
         dm = hm ? (m_qt * 24) / 16 : 0;
         s  = m_w + dp - dm;
         if (s < 0)   s = 0;
         if (s > 255) s = 255;
         e.cur = pre ? m_w : 0;
         e.w   = ld ? lv : s;
         e.pt  = pre ? 15 : (m_pt > 0 ? m_pt - 1 : 0);
         e.qt  = post ? 15 : (m_qt > 0 ? m_qt - 1 : 0);
         e.ltp = hp ? 1 : 0;
         e.ltd = hm ? 1 : 0;
      end
      m_w  = e.w;
      m_pt = e.pt;
      m_qt = e.qt;
      exp_q.push_back(e);

      rst         = r;
      pre_spike   = pre;
      post_spike  = post;
      learn_en    = le;
      weight_load = ld;
      weight_in   = 8'(lv);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk("current", int'(current), e.cur);
      chk("weight", int'(weight), e.w);
      chk("pre_trace", int'(pre_trace), e.pt);
      chk("post_trace", int'(post_trace), e.qt);
      chk("ltp_event", int'(ltp_event), e.ltp);
      chk("ltd_event", int'(ltd_event), e.ltd);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
   endtask

   initial begin
      rst = 1'b1; pre_spike = 1'b0; post_spike = 1'b0;
      learn_en = 1'b1; weight_load = 1'b0; weight_in = '0;
      #1;

      // 1. reset
      do_reset();
      chk("rst_weight", int'(weight), 64);
      chk("rst_current", int'(current), 0);

      // 2. current pulse and trace decay
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
      chk("s2_current_e0", int'(current), 64);
      chk("s2_trace_e0", int'(pre_trace), 15);
      idle(1);
      chk("s2_current_e1", int'(current), 0);
      chk("s2_trace_e1", int'(pre_trace), 14);
      idle(14);
      chk("s2_trace_e15", int'(pre_trace), 0);
      idle(2);
      chk("s2_trace_stays0", int'(pre_trace), 0);

      // 3. LTP
      do_reset();
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
      idle(2);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
      chk("s3_weight", int'(weight), 90);
      chk("s3_ltp_high", int'(ltp_event), 1);
      idle(1);
      chk("s3_ltp_low", int'(ltp_event), 0);

      // 4. LTD, current uses old weight
      do_reset();
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
      idle(1);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
      chk("s4_weight", int'(weight), 43);
      chk("s4_current", int'(current), 64);
      chk("s4_ltd_high", int'(ltd_event), 1);
      idle(1);
      chk("s4_ltd_low", int'(ltd_event), 0);

      // 5. saturation high and low
      do_reset();
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 250);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
      chk("s5_sat_high", int'(weight), 255);
      do_reset();
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
      chk("s5_sat_low", int'(weight), 0);

      // same-edge pre and post with empty traces: no change
      do_reset();
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
      chk("both_zero_traces", int'(weight), 64);

      // 6a. learning disabled
      do_reset();
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      chk("s6_frozen_weight", int'(weight), 64);
      chk("s6_frozen_ltp", int'(ltp_event), 0);

      // 6b. load overrides pending LTP
      do_reset();
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 100);
      chk("s6_load", int'(weight), 100);

      // 6c. reset mid-trace
      do_reset();
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
      idle(4);
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
      chk("s6_rst_trace", int'(pre_trace), 0);

      // random soak against the model
      do_reset();
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 63) == 0),
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 7) != 0),
              ($urandom_range(0, 31) == 0),
              int'($urandom_range(0, 255)));
      end

      chk("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
